// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_pkg
//  Purpose  : Shared line states, FSM encoding and constants for the USB
//             full-speed transmit encoder.
//  Revision : 1.0  initial release
// ============================================================================
package usb_pkg;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_BYTE           = 8'h80;
    localparam int         STUFF_LIMIT_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        EOP1 = 3'd3,
        EOP2 = 3'd4,
        EOPJ = 3'd5
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_nrzi_stuff.sv
`default_nettype none
// ============================================================================
//  Module   : usb_nrzi_stuff
//  Purpose  : Serial bit in, NRZI line level out, with a ones counter that
//             requests a stuffed zero from the parent.
//  Revision : 1.0  initial release
// ============================================================================
module usb_nrzi_stuff
    import usb_pkg::*;
#(
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic init_i,
    input  logic bit_en_i,
    input  logic bit_i,
    output logic stall_o,
    output logic line_j_o
);

    localparam logic [2:0] ONES_LIMIT = 3'(STUFF_LIMIT);

    logic       nrzi_j_q, nrzi_j_d;
    logic [2:0] ones_q, ones_d;
    logic       base_j;
    logic [2:0] base_ones;
    logic       stuff;

    // init restarts from J with a cleared counter in the same cycle the first bit is applied
    always_comb begin
        base_j    = init_i ? 1'b1 : nrzi_j_q;
        base_ones = init_i ? 3'd0 : ones_q;
        stuff     = (base_ones == ONES_LIMIT);
        nrzi_j_d  = nrzi_j_q;
        ones_d    = ones_q;
        if (bit_en_i) begin
            if (stuff || !bit_i) begin
                nrzi_j_d = ~base_j;
                ones_d   = 3'd0;
            end else begin
                nrzi_j_d = base_j;
                ones_d   = base_ones + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nrzi_j_q <= 1'b1;
            ones_q   <= 3'd0;
        end else begin
            nrzi_j_q <= nrzi_j_d;
            ones_q   <= ones_d;
        end
    end

    assign stall_o  = (ones_q == ONES_LIMIT);
    assign line_j_o = nrzi_j_q;

endmodule
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_encoder
//  Purpose  : Full-speed USB transmit encoder: SYNC, LSB-first data with bit
//             stuffing and NRZI, EOP; bytes taken over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [1:0] USBdata,
    output logic       tx_oe,
    output logic       busy,
    output logic       tx_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    shreg_q, shreg_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          last_q, last_d;

    logic tick;
    logic stall;
    logic nrzi_init;
    logic bit_en;
    logic bit_val;
    logic line_j;

    assign tick = (cnt_q == CNT_LAST);

    // shreg holds the bits still to be sent; the bit on the line lives in the NRZI stage
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        last_d    = last_q;
        nrzi_init = 1'b0;
        bit_en    = 1'b0;
        bit_val   = 1'b0;
        tx_ready  = 1'b0;
        tx_err    = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d   = SYNC;
                    cnt_d     = '0;
                    shreg_d   = SYNC_BYTE[7:1];
                    bit_idx_d = 3'd0;
                    last_d    = 1'b0;
                    nrzi_init = 1'b1;
                    bit_en    = 1'b1;
                    bit_val   = SYNC_BYTE[0];
                end
            end
            SYNC, DATA: begin
                if (tick) begin
                    if (stall) begin
                        bit_en = 1'b1;
                    end else if (bit_idx_q != 3'd7) begin
                        bit_en    = 1'b1;
                        bit_val   = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[6:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (last_q) begin
                        state_d = EOP1;
                    end else if (tx_valid) begin
                        state_d   = DATA;
                        tx_ready  = 1'b1;
                        bit_en    = 1'b1;
                        bit_val   = tx_data[0];
                        shreg_d   = tx_data[7:1];
                        bit_idx_d = 3'd0;
                        last_d    = tx_last;
                    end else begin
                        tx_err  = 1'b1;
                        state_d = EOP1;
                    end
                end
            end
            EOP1:    if (tick) state_d = EOP2;
            EOP2:    if (tick) state_d = EOPJ;
            EOPJ:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= 3'd0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            last_q    <= last_d;
        end
    end

    usb_nrzi_stuff #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_nrzi_stuff (
        .clk      (clk),
        .rst      (rst),
        .init_i   (nrzi_init),
        .bit_en_i (bit_en),
        .bit_i    (bit_val),
        .stall_o  (stall),
        .line_j_o (line_j)
    );

    always_comb begin
        case (state_q)
            SYNC, DATA: USBdata = line_j ? LINE_J : LINE_K;
            EOP1, EOP2: USBdata = LINE_SE0;
            default:    USBdata = LINE_J;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign tx_oe = (state_q != IDLE);

endmodule
`default_nettype wire
